// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared FSM encoding and add-3 correction constants for the binary-to-BCD converter.
package bin_to_bcd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;
endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d,
  output logic [DIGIT_W-1:0] o_d
);
  assign o_d = (i_d >= ADJ_THRESH) ? i_d + ADJ_ADD : i_d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary-to-BCD converter with valid/ready on both sides.
// Define BIN_TO_BCD_OVF_EN to get a sticky overflow flag; otherwise ovf is tied low.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    ovf
);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_W-1:0]   r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_adj;
  logic [CAT_W-1:0]   w_cat;
  logic               w_accept;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d(r_bcd[d*DIGIT_W +: DIGIT_W]),
      .o_d(w_adj[d*DIGIT_W +: DIGIT_W])
    );
  end
  assign w_cat    = {w_adj, r_sh};
  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
  // The bit leaving the top digit is rotated into the spent low end of the shift
  // register; it can never climb back into the BCD field within one conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_sh        <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_sh       <= bin;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(BIN_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_sh} <= {w_cat[CAT_W-2:0], w_cat[CAT_W-1]};
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BIN_TO_BCD_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (!rst_n)                                 r_ovf <= 1'b0;
    else if (w_accept)                          r_ovf <= 1'b0;
    else if (r_state == SHIFT && w_cat[CAT_W-1]) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: vector table, random and corner-sequence checks of bin_to_bcd_seq against an arithmetic model.
module tb_bin_to_bcd_seq;
`ifdef BIN_TO_BCD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
  logic [7:0]  bin2;
  logic [7:0]  bcd2;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .ovf(ovf)
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bcd(bcd2), .ovf(ovf2)
  );
  function automatic logic [11:0] to_bcd(input int v, input int digits);
    logic [11:0] r = '0;
    int x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic do_conv(input logic [7:0] b, input logic [11:0] exp, input string nm);
    int t = 0;
    int lat = 0;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    bin       = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin      = 8'($urandom);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'd8);
    check({nm, "_bcd"}, 32'(bcd), 32'(exp));
    check({nm, "_ovf"}, 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    check({nm, "_vdrop"}, 32'(out_valid), 32'd0);
    check({nm, "_rdy"}, 32'(in_ready), 32'd1);
  endtask
  task automatic do_conv2(input logic [7:0] b, input string nm);
    int t = 0;
    @(negedge clk);
    while (!in_ready2 && t < 40) begin
      @(negedge clk);
      t++;
    end
    in_valid2 = 1'b1;
    bin2      = b;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    t = 0;
    while (!out_valid2 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({nm, "_lat"}, 32'(t), 32'd8);
    check({nm, "_bcd"}, 32'(bcd2), 32'(to_bcd(int'(b), 2)));
    check({nm, "_ovf"}, 32'(ovf2), 32'(OVF_EN && b >= 8'd100));
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [7:0]  b;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[7];
  initial begin
    int last_acc;
    logic acc;
    logic [7:0] snap;
    logic [7:0] q[$];
    logic [7:0] r;
    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd10,  12'h010};
    vecs[4] = '{8'd99,  12'h099};
    vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd128, 12'h128};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; bin2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) do_conv(vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      do_conv(r, to_bcd(int'(r), 3), $sformatf("rnd%0d", i));
    end
    // backpressure
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 8'd42;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_bcd", 32'(bcd), 32'h042);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    // reset at the fourth shift cycle
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 8'd200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_noval", 32'(out_valid), 32'd0);
    end
    do_conv(8'd7, 12'h007, "post_rst");
    do_conv2(8'd100, "ovf100");
    do_conv2(8'd55, "ovf55");
    for (int i = 0; i < 6; i++) do_conv2(8'($urandom), $sformatf("d2rnd%0d", i));
    // in_valid held high with a fresh bin every cycle
    last_acc  = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      bin  = 8'($urandom);
      acc  = in_ready && in_valid;
      snap = bin;
      @(posedge clk);
      if (acc) begin
        q.push_back(snap);
        if (last_acc >= 0) check("gate_period", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
      end
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("gate_spurious", 32'd1, 32'd0);
        else check("gate_bcd", 32'(bcd), 32'(to_bcd(int'(q.pop_front()), 3)));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("gate_spurious", 32'd1, 32'd0);
        else check("gate_bcd", 32'(bcd), 32'(to_bcd(int'(q.pop_front()), 3)));
      end
    end
    check("gate_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
